// File: rtl/bandgap_enable_ctrl.sv
// Bandgap enable sequencer: Wishbone register file, pad-request synchroniser
// and a settle/cooldown FSM that owns the bandgap enable pin.
//
// state        | meaning
// -------------+----------------------------------------------------------
// ST_OFF       | bandgap disabled, waiting for a request
// ST_SETTLING  | enabled, down-counting the settle window
// ST_ON        | enabled and declared settled (ready)
// ST_COOLDOWN  | disabled, down-counting the minimum off-time
module bandgap_enable_ctrl #(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          CNT_W      = 16,
  parameter int unsigned SETTLE_RST = 1000,
  parameter int unsigned COOL_RST   = 100
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        pad_en_i,
  output logic        bg_en_o,
  output logic        bg_ready_o,
  output logic        irq_o
);

  typedef enum logic [1:0] {
    ST_OFF      = 2'd0,
    ST_SETTLING = 2'd1,
    ST_ON       = 2'd2,
    ST_COOLDOWN = 2'd3
  } state_t;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_SETTLE = 2'd1;
  localparam logic [1:0] OFF_STATUS = 2'd2;
  localparam logic [1:0] OFF_COOL   = 2'd3;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               bg_en_q, bg_en_d;
  logic               ready_q, ready_d;
  logic               rdy_set;

  logic [2:0]         ctrl_q;
  logic [CNT_W-1:0]   settle_q;
  logic [CNT_W-1:0]   cool_q;
  logic               sticky_q;

  logic               ack_q;
  logic [31:0]        dat_q;
  logic [31:0]        rd_data;
  logic               adr_hit;
  logic               bus_req;
  logic               wr_en;
  logic               rd_en;
  logic [1:0]         reg_off;
  logic               wr_ctrl, wr_settle, wr_status, wr_cool;
  logic               w1c_sticky;

  logic [1:0]         sync_q;
  logic               pad_sync;
  logic               req;

  logic               unused_bits;
  assign unused_bits = ^{wbs_adr_i[1:0], wbs_dat_i[31:16], wbs_sel_i[3:2]};

  // Counter registers only span the low two byte lanes.
  function automatic logic [CNT_W-1:0] merge_cnt(
    input logic [CNT_W-1:0] old_v,
    input logic [15:0]      new_v,
    input logic [1:0]       sel
  );
    logic [CNT_W-1:0] r;
    for (int i = 0; i < CNT_W; i++) begin
      r[i] = sel[i/8] ? new_v[i] : old_v[i];
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------
  // Wishbone slave
  // ---------------------------------------------------------------------
  assign adr_hit = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  // Blocking on ack_q keeps at least one idle cycle between acks.
  assign bus_req = wbs_stb_i & wbs_cyc_i & adr_hit & ~ack_q;
  assign wr_en   = bus_req & wbs_we_i;
  assign rd_en   = bus_req & ~wbs_we_i;
  assign reg_off = wbs_adr_i[3:2];

  assign wr_ctrl    = wr_en && (reg_off == OFF_CTRL);
  assign wr_settle  = wr_en && (reg_off == OFF_SETTLE);
  assign wr_status  = wr_en && (reg_off == OFF_STATUS);
  assign wr_cool    = wr_en && (reg_off == OFF_COOL);
  assign w1c_sticky = wr_status & wbs_sel_i[0] & wbs_dat_i[3];

  always_comb begin
    rd_data = '0;
    case (reg_off)
      OFF_CTRL:   rd_data[2:0]       = ctrl_q;
      OFF_SETTLE: rd_data[CNT_W-1:0] = settle_q;
      OFF_STATUS: rd_data[3:0]       = {sticky_q, state_q, ready_q};
      OFF_COOL:   rd_data[CNT_W-1:0] = cool_q;
      default:    rd_data            = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= bus_req;
      dat_q <= rd_en ? rd_data : '0;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;

  // ---------------------------------------------------------------------
  // Configuration registers
  // ---------------------------------------------------------------------
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      ctrl_q   <= '0;
      settle_q <= CNT_W'(SETTLE_RST);
      cool_q   <= CNT_W'(COOL_RST);
    end else begin
      if (wr_ctrl && wbs_sel_i[0]) begin
        ctrl_q <= wbs_dat_i[2:0];
      end
      if (wr_settle) begin
        settle_q <= merge_cnt(settle_q, wbs_dat_i[15:0], wbs_sel_i[1:0]);
      end
      if (wr_cool) begin
        cool_q <= merge_cnt(cool_q, wbs_dat_i[15:0], wbs_sel_i[1:0]);
      end
    end
  end

  // Hardware set beats a simultaneous software clear.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      sticky_q <= 1'b0;
    end else if (rdy_set) begin
      sticky_q <= 1'b1;
    end else if (w1c_sticky) begin
      sticky_q <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Request selection
  // ---------------------------------------------------------------------
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], pad_en_i};
    end
  end

  assign pad_sync = sync_q[1];
  assign req      = ctrl_q[2] ? pad_sync : ctrl_q[0];

  // ---------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
      bg_en_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bg_en_q <= bg_en_d;
      ready_q <= ready_d;
    end
  end

  // Counters only decrement from a loaded value and stop at zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdy_set = 1'b0;
    case (state_q)
      ST_OFF: begin
        if (req) begin
          state_d = ST_SETTLING;
          cnt_d   = settle_q;
        end
      end
      ST_SETTLING: begin
        if (!req) begin
          state_d = ST_COOLDOWN;
          cnt_d   = cool_q;
        end else if (cnt_q == '0) begin
          state_d = ST_ON;
          rdy_set = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_ON: begin
        if (!req) begin
          state_d = ST_COOLDOWN;
          cnt_d   = cool_q;
        end
      end
      ST_COOLDOWN: begin
        if (cnt_q == '0) begin
          state_d = ST_OFF;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_OFF;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decoded from the next state so they come straight off flops.
  always_comb begin
    bg_en_d = 1'b0;
    ready_d = 1'b0;
    case (state_d)
      ST_SETTLING: bg_en_d = 1'b1;
      ST_ON: begin
        bg_en_d = 1'b1;
        ready_d = 1'b1;
      end
      default: begin
        bg_en_d = 1'b0;
        ready_d = 1'b0;
      end
    endcase
  end

  assign bg_en_o    = bg_en_q;
  assign bg_ready_o = ready_q;
  assign irq_o      = ctrl_q[1] & sticky_q;

endmodule

// File: tb/tb_bandgap_enable_ctrl.sv
// Directed bench for bandgap_enable_ctrl: register access, settle/cooldown
// timing, W1C, pad path and reset behaviour.
module tb_bandgap_enable_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_i;
  logic        ack;
  logic [31:0] dat_o;
  logic        pad_en;
  logic        bg_en, bg_ready, irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bandgap_enable_ctrl dut (
    .wb_clk_i   (clk),
    .wb_rst_ni  (rst_n),
    .wbs_stb_i  (stb),
    .wbs_cyc_i  (cyc),
    .wbs_we_i   (we),
    .wbs_sel_i  (sel),
    .wbs_adr_i  (adr),
    .wbs_dat_i  (dat_i),
    .wbs_ack_o  (ack),
    .wbs_dat_o  (dat_o),
    .pad_en_i   (pad_en),
    .bg_en_o    (bg_en),
    .bg_ready_o (bg_ready),
    .irq_o      (irq)
  );

  localparam logic [31:0] BASE = 32'h3000_0000;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Called at a negedge; returns at the negedge following the acking edge.
  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] rd);
    logic got;
    got = 1'b0;
    rd  = '0;
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_i = d; sel = s;
    for (int i = 0; i < 4 && !got; i++) begin
      @(posedge clk);
      #1;
      if (ack) begin
        got = 1'b1;
        rd  = dat_o;
      end
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    @(negedge clk);
    check("wb_ack_seen", {31'b0, got}, 32'd1);
  endtask

  task automatic wb_write(input logic [31:0] off, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] rd;
    wb_xfer(1'b1, BASE + off, d, s, rd);
  endtask

  task automatic wb_read(input string tag, input logic [31:0] off, input logic [31:0] exp);
    logic [31:0] rd;
    wb_xfer(1'b0, BASE + off, 32'h0, 4'hf, rd);
    check(tag, rd, exp);
  endtask

  initial begin
    rst_n = 1'b0; stb = 1'b0; cyc = 1'b0; we = 1'b0;
    sel = 4'h0; adr = '0; dat_i = '0; pad_en = 1'b0;

    // Reset
    step(3);
    check("rst_bg_en", {31'b0, bg_en}, 32'd0);
    check("rst_ready", {31'b0, bg_ready}, 32'd0);
    check("rst_irq", {31'b0, irq}, 32'd0);
    check("rst_ack", {31'b0, ack}, 32'd0);
    check("rst_dat", dat_o, 32'd0);
    rst_n = 1'b1;
    step(1);

    wb_read("rd_settle_rst", 32'h4, 32'd1000);
    wb_read("rd_status_rst", 32'h8, 32'd0);
    wb_read("rd_cool_rst", 32'hC, 32'd100);
    wb_read("rd_ctrl_rst", 32'h0, 32'd0);

    // Non-matching address: never acked
    step(1);
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE + 32'h10; sel = 4'hf;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("nomatch_ack", {31'b0, ack}, 32'd0);
    end
    // Held strobe: ack, forced low, ack again
    adr = BASE + 32'h4;
    @(posedge clk); #1;
    check("held_ack1", {31'b0, ack}, 32'd1);
    @(posedge clk); #1;
    check("held_ack_gap", {31'b0, ack}, 32'd0);
    check("held_dat_gap", dat_o, 32'd0);
    @(posedge clk); #1;
    check("held_ack2", {31'b0, ack}, 32'd1);
    check("held_dat2", dat_o, 32'd1000);
    stb = 1'b0; cyc = 1'b0;
    @(negedge clk);

    // SETTLE = 5, EN_REQ + IRQ_EN
    wb_write(32'h4, 32'd5, 4'hf);
    check("wr_ack_dat_zero", dat_o, 32'd0);
    wb_write(32'h0, 32'h3, 4'hf);
    check("en_after_ack", {31'b0, bg_en}, 32'd0);
    step(1);
    check("en_e1", {31'b0, bg_en}, 32'd1);
    check("ready_e1", {31'b0, bg_ready}, 32'd0);
    for (int k = 2; k <= 6; k++) begin
      step(1);
      check("ready_settling", {31'b0, bg_ready}, 32'd0);
      check("irq_settling", {31'b0, irq}, 32'd0);
    end
    step(1);
    check("ready_e7", {31'b0, bg_ready}, 32'd1);
    check("irq_e7", {31'b0, irq}, 32'd1);
    check("en_e7", {31'b0, bg_en}, 32'd1);
    wb_read("status_on", 32'h8, 32'hD);

    // W1C of RDY_STICKY while ON
    wb_write(32'h8, 32'h8, 4'h1);
    check("w1c_irq", {31'b0, irq}, 32'd0);
    check("w1c_ready", {31'b0, bg_ready}, 32'd1);
    wb_read("status_w1c", 32'h8, 32'h5);

    // COOLDOWN = 3, drop to OFF
    wb_write(32'hC, 32'd3, 4'hf);
    wb_write(32'h0, 32'h2, 4'hf);
    step(1);
    check("drop_on_en", {31'b0, bg_en}, 32'd0);
    check("drop_on_ready", {31'b0, bg_ready}, 32'd0);
    step(6);
    wb_read("status_off", 32'h8, 32'h0);

    // Drop during SETTLING at count 2, re-request during cooldown
    wb_write(32'h0, 32'h3, 4'hf);
    step(3);
    wb_write(32'h0, 32'h2, 4'hf);
    check("drop_set_still_en", {31'b0, bg_en}, 32'd1);
    step(1);
    check("drop_set_en", {31'b0, bg_en}, 32'd0);
    check("drop_set_ready", {31'b0, bg_ready}, 32'd0);
    wb_write(32'h0, 32'h3, 4'hf);
    check("cool_en_w0", {31'b0, bg_en}, 32'd0);
    for (int k = 1; k <= 3; k++) begin
      step(1);
      check("cool_en", {31'b0, bg_en}, 32'd0);
      check("cool_ready", {31'b0, bg_ready}, 32'd0);
    end
    step(1);
    check("resettle_en", {31'b0, bg_en}, 32'd1);

    // Pad path with SETTLE = 0; EN_REQ ignored when PAD_SEL
    wb_write(32'h0, 32'h4, 4'hf);
    step(8);
    wb_write(32'h4, 32'd0, 4'hf);
    wb_write(32'h0, 32'h5, 4'hf);
    step(3);
    check("padsel_ignore_en", {31'b0, bg_en}, 32'd0);
    wb_read("status_pad_off", 32'h8, 32'h0);
    pad_en = 1'b1;
    step(1);
    check("pad_p1", {31'b0, bg_en}, 32'd0);
    step(1);
    check("pad_p2", {31'b0, bg_en}, 32'd0);
    step(1);
    check("pad_p3_en", {31'b0, bg_en}, 32'd1);
    check("pad_p3_ready", {31'b0, bg_ready}, 32'd0);
    step(1);
    check("pad_p4_ready", {31'b0, bg_ready}, 32'd1);
    check("pad_p4_irq_off", {31'b0, irq}, 32'd0);

    // Reset while ON
    wb_write(32'h0, 32'h7, 4'hf);
    check("pre_rst_irq", {31'b0, irq}, 32'd1);
    rst_n = 1'b0;
    step(1);
    check("midrst_en", {31'b0, bg_en}, 32'd0);
    check("midrst_ready", {31'b0, bg_ready}, 32'd0);
    check("midrst_irq", {31'b0, irq}, 32'd0);
    check("midrst_ack", {31'b0, ack}, 32'd0);
    rst_n = 1'b1;
    step(1);
    wb_read("ctrl_after_rst", 32'h0, 32'h0);
    wb_read("status_after_rst", 32'h8, 32'h0);
    step(3);
    check("post_rst_en", {31'b0, bg_en}, 32'd0);

    // Byte-lane write to SETTLE: only byte 1 changes (0x03E8 -> 0x12E8)
    wb_write(32'h4, 32'h0000_1234, 4'b0010);
    wb_read("settle_bytesel", 32'h4, 32'h12E8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bandgap_enable_ctrl.md
# bandgap_enable_ctrl

Digital sequencer that sits directly upstream of the bandgap reference macro in the user project area and owns its enable pin. Accepts an enable request from a Wishbone register or from a GPIO pad (synchronised), drives the bandgap enable with a programmable settle window and a minimum off-time, and reports a registered ready flag plus an interrupt once the reference is declared settled. Register values are readable and writable over Wishbone.

## Interface
- BASE_ADDR, 32'h3000_0000, Wishbone base; decode matches wbs_adr_i[31:4] == BASE_ADDR[31:4]
- CNT_W, 16, width of settle and cooldown counters; legal range 4..16
- SETTLE_RST, 16'd1000, reset value of SETTLE register
- COOL_RST, 16'd100, reset value of COOLDOWN register
- wb_clk_i  input  1  the single clock for the block; all logic is on its rising edge
- wb_rst_ni  input  1  synchronous, active-low reset
- wbs_stb_i, wbs_cyc_i, wbs_we_i  input  1  Wishbone classic strobe, cycle, write enable
- wbs_sel_i  input  4  byte selects
- wbs_adr_i  input  32  byte address
- wbs_dat_i  input  32  write data
- wbs_ack_o  output  1  one-cycle acknowledge
- wbs_dat_o  output  32  read data, zero when not acking a read
- pad_en_i  input  1  asynchronous enable request from GPIO pad
- bg_en_o  output  1  enable to the bandgap macro
- bg_ready_o  output  1  reference declared settled
- irq_o  output  1  level interrupt

## Operation
- Registers, at offsets 0x0, 0x4, 0x8, 0xC; unused bits read 0; writes honour wbs_sel_i per byte:
  - 0x0 CTRL: [0] EN_REQ, [1] IRQ_EN, [2] PAD_SEL; reset 0
  - 0x4 SETTLE: [CNT_W-1:0]; reset SETTLE_RST
  - 0x8 STATUS, read-only except bit 3: [0] READY, [2:1] state (OFF=0, SETTLING=1, ON=2, COOLDOWN=3), [3] RDY_STICKY, write-1-to-clear
  - 0xC COOLDOWN: [CNT_W-1:0]; reset COOL_RST
- Effective request: req = PAD_SEL ? pad_sync : EN_REQ. pad_sync comes from a 2-flop synchroniser on pad_en_i, reset to 0.
- FSM, registered:
  - OFF: bg_en_o = 0. When req = 1: go to SETTLING and load the counter with SETTLE.
  - SETTLING: bg_en_o = 1.
    - If req = 0: go to COOLDOWN and load the counter with COOLDOWN. This has priority.
    - Otherwise, if the counter is 0: go to ON and set RDY_STICKY.
    - Otherwise decrement the counter.
  - ON: bg_en_o = 1, READY = 1. When req = 0: go to COOLDOWN and load the counter with COOLDOWN.
  - COOLDOWN: bg_en_o = 0. If the counter is 0, go to OFF; otherwise decrement. req is ignored in this state.
- bg_ready_o = (state == ON).
- irq_o = IRQ_EN & RDY_STICKY.
- If an SW W1C write to RDY_STICKY lands in the same cycle as a hardware set, the set wins.
- SETTLE or COOLDOWN writes in mid-count do not affect the running count. They apply at the next load.

## Timing
- Reset, while wb_rst_ni = 0 at a clock edge:
  - wbs_ack_o = 0, wbs_dat_o = 0, bg_en_o = 0, bg_ready_o = 0, irq_o = 0
  - state = OFF, counter = 0, synchroniser flops = 0, registers at their reset values
  - Asserting reset mid-SETTLING or mid-ON drops bg_en_o at the same edge. No cooldown is enforced.
- Wishbone:
  - wbs_ack_o rises in the cycle after stb & cyc & address match, lasts exactly one cycle, then is forced low for one cycle. No back-to-back acks.
  - A write is applied at the edge that raises the ack.
  - Read data is registered and valid while ack is high.
  - Non-matching addresses get no ack.
- Latency:
  - EN_REQ write acked at edge E: state = SETTLING and bg_en_o = 1 after edge E+1.
  - SETTLING lasts SETTLE+1 cycles; bg_ready_o rises after edge E+SETTLE+2.
  - irq_o is high the same cycle as bg_ready_o when IRQ_EN = 1.
  - Pad path adds 2 cycles of synchroniser delay.
  - A req drop in ON or SETTLING lowers bg_en_o and bg_ready_o one edge later.
  - COOLDOWN lasts COOLDOWN+1 cycles.
- Boundaries:
  - SETTLE = 0: one SETTLING cycle.
  - SETTLE = 2^CNT_W-1: no wrap; the counter only decrements from the loaded value.
  - req toggling faster than cooldown is absorbed; the FSM re-enters SETTLING only from OFF.

## Test plan
- Reset release, then read 0x4, 0x8, 0xC -> 1000, 0, 100; bg_en_o = 0 and irq_o = 0 throughout reset.
- Write SETTLE = 5 and CTRL = 0x3 (EN_REQ, IRQ_EN) -> bg_en_o high 1 cycle after the write ack; bg_ready_o and irq_o high exactly 7 cycles after the ack; STATUS reads 0xD.
- W1C: write STATUS = 0x8 while ON -> irq_o low the next cycle; bg_ready_o stays 1; STATUS reads 0x5.
- Drop EN_REQ during SETTLING at count 2 with COOLDOWN = 3 -> bg_en_o low next cycle, bg_ready_o never rises; set EN_REQ = 1 during cooldown -> SETTLING entered only after 4 COOLDOWN cycles plus 1 OFF cycle.
- PAD_SEL = 1 with SETTLE = 0: raise pad_en_i -> bg_en_o high 3 cycles later and bg_ready_o 1 cycle after that; EN_REQ is ignored.
- Assert wb_rst_ni = 0 while ON -> bg_en_o, bg_ready_o and irq_o low after that edge; CTRL reads 0 after release.
